// File: rtl/spi_device_top.sv
// SPI device (CPHA=0 only) with a register bus: receives bytes into an RX FIFO,
// transmits from a TXDATA register. SPI inputs are oversampled in the clk_i domain.
module spi_device_top #(
  parameter bit          CPOL      = 1'b0,
  parameter int unsigned RxDepth   = 16,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegAddr   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic                 spi_sck_i,
  input  logic                 spi_cs_ni,
  input  logic                 spi_copi_i,
  output logic                 spi_cipo_o,
  output logic                 rx_irq_o
);

  localparam int unsigned PtrW = (RxDepth > 1) ? $clog2(RxDepth) : 1;
  localparam int unsigned CntW = $clog2(RxDepth + 1);

  localparam logic [RegAddr-1:0] AddrRxdata = RegAddr'('h0);
  localparam logic [RegAddr-1:0] AddrStatus = RegAddr'('h4);
  localparam logic [RegAddr-1:0] AddrTxdata = RegAddr'('h8);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e state_q, state_d;

  logic [1:0] sck_sync_q, cs_sync_q, copi_sync_q;
  logic       sck_prev_q, cs_prev_q;
  logic       sck_s, cs_s, copi_s;
  logic       lead_edge, trail_edge, cs_fall, cs_rise;
  logic       start, stop, lead_en, trail_en;

  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q, tx_shift_q, rx_next;
  logic [7:0] tx_data_q;
  logic       push, push_ok, pop;

  logic [7:0]      fifo_mem [RxDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            empty, full, overflow_q;

  logic [RegAddr-1:0]   reg_addr;
  logic                 rd_req, wr_req, ovf_clear;
  logic [DataWidth-1:0] rdata_d;

  logic unused_inputs;
  assign unused_inputs = ^{device_addr_i[AddrWidth-1:RegAddr], device_be_i[3:1],
                           device_wdata_i[DataWidth-1:8]};

  // SCK resets to its idle level and CS to "asserted" so that a CS held low
  // across reset release does not look like a fresh falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= {2{CPOL}};
      sck_prev_q  <= CPOL;
      cs_sync_q   <= 2'b00;
      cs_prev_q   <= 1'b0;
      copi_sync_q <= 2'b00;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck_i};
      sck_prev_q  <= sck_sync_q[1];
      cs_sync_q   <= {cs_sync_q[0], spi_cs_ni};
      cs_prev_q   <= cs_sync_q[1];
      copi_sync_q <= {copi_sync_q[0], spi_copi_i};
    end
  end

  assign sck_s      = sck_sync_q[1];
  assign cs_s       = cs_sync_q[1];
  assign copi_s     = copi_sync_q[1];
  assign lead_edge  = CPOL ? (sck_prev_q & ~sck_s) : (~sck_prev_q & sck_s);
  assign trail_edge = CPOL ? (~sck_prev_q & sck_s) : (sck_prev_q & ~sck_s);
  assign cs_fall    = cs_prev_q & ~cs_s;
  assign cs_rise    = ~cs_prev_q & cs_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    stop     = 1'b0;
    lead_en  = 1'b0;
    trail_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          lead_en  = lead_edge;
          trail_en = trail_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_next = {rx_shift_q[6:0], copi_s};
  assign push    = lead_en && (bit_cnt_q == 3'd7);

  // A wrapped bit counter on a trailing edge means a whole byte has gone out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
    end else if (start) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= tx_data_q;
    end else if (stop) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
    end else begin
      if (lead_en) begin
        rx_shift_q <= rx_next;
        bit_cnt_q  <= bit_cnt_q + 1'b1;
      end
      if (trail_en) begin
        tx_shift_q <= (bit_cnt_q == 3'd0) ? tx_data_q : {tx_shift_q[6:0], 1'b0};
      end
    end
  end

  assign spi_cipo_o = (state_q == ACTIVE) & tx_shift_q[7];

  assign reg_addr  = device_addr_i[RegAddr-1:0];
  assign rd_req    = device_req_i & ~device_we_i;
  assign wr_req    = device_req_i & device_we_i & device_be_i[0];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(RxDepth));
  assign pop       = rd_req && (reg_addr == AddrRxdata) && !empty;
  assign push_ok   = push & ~full;
  assign ovf_clear = wr_req && (reg_addr == AddrStatus) && device_wdata_i[2];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RxDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // An overflow in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      if (push && full)   overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;
      if (wr_req && (reg_addr == AddrTxdata)) tx_data_q <= device_wdata_i[7:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (reg_addr)
        AddrRxdata: if (!empty) rdata_d = DataWidth'(fifo_mem[rd_ptr_q]);
        AddrStatus: rdata_d = DataWidth'({state_q == ACTIVE, overflow_q, full, empty});
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rdata_d;
    end
  end

  assign rx_irq_o = ~empty;

endmodule

// File: tb/tb_spi_device_top.sv
// Directed bench for spi_device_top: a CPOL=0 and a CPOL=1 instance driven by
// a bit-banged SPI host model and a simple register-bus master.
module tb_spi_device_top;

  localparam int Half = 8;

  typedef struct {
    int         inst;
    logic [7:0] txdata;
    logic [7:0] host;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        sck0, sck1, csn0, csn1, copi;
  logic        rvalid0, rvalid1, cipo0, cipo1, irq0, irq1;
  logic [31:0] rdata0, rdata1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic [7:0]  m;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  spi_device_top #(.CPOL(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .device_req_i(req0), .device_addr_i(addr),
    .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid0), .device_rdata_o(rdata0), .spi_sck_i(sck0),
    .spi_cs_ni(csn0), .spi_copi_i(copi), .spi_cipo_o(cipo0), .rx_irq_o(irq0)
  );

  spi_device_top #(.CPOL(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .device_req_i(req1), .device_addr_i(addr),
    .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid1), .device_rdata_o(rdata1), .spi_sck_i(sck1),
    .spi_cs_ni(csn1), .spi_copi_i(copi), .spi_cipo_o(cipo1), .rx_irq_o(irq1)
  );

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic getCipo(input int inst);
    return (inst == 0) ? cipo0 : cipo1;
  endfunction

  function automatic logic getIrq(input int inst);
    return (inst == 0) ? irq0 : irq1;
  endfunction

  task automatic setSck(input int inst, input logic v);
    if (inst == 0) sck0 = v;
    else           sck1 = v;
  endtask

  task automatic setCs(input int inst, input logic v);
    if (inst == 0) csn0 = v;
    else           csn1 = v;
  endtask

  // Called on a falling clk edge; response is sampled one cycle later.
  task automatic busAccess(input int inst, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] r);
    we    = wr;
    addr  = a;
    wdata = d;
    be    = wr ? 4'h1 : 4'h0;
    if (inst == 0) req0 = 1'b1;
    else           req1 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    we   = 1'b0;
    checkOutput("rvalid", (inst == 0) ? rvalid0 : rvalid1, 32'h1);
    r = (inst == 0) ? rdata0 : rdata1;
  endtask

  task automatic regWrite(input int inst, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    busAccess(inst, 1'b1, a, d, dummy);
  endtask

  task automatic regRead(input int inst, input logic [31:0] a, output logic [31:0] r);
    busAccess(inst, 1'b0, a, 32'h0, r);
  endtask

  task automatic csAssert(input int inst);
    setCs(inst, 1'b0);
    waitClk(Half);
  endtask

  task automatic csRelease(input int inst);
    setCs(inst, 1'b1);
    waitClk(Half);
  endtask

  // Host side of CPHA=0: data valid before the leading edge, changed on the trailing edge.
  task automatic sendBits(input int inst, input logic [7:0] data, input int nbits,
                          output logic [7:0] miso);
    logic idle;
    idle = (inst == 1);
    miso = 8'h00;
    copi = data[7];
    waitClk(2);
    for (int i = 0; i < nbits; i++) begin
      setSck(inst, ~idle);
      miso[7-i] = getCipo(inst);
      waitClk(Half);
      setSck(inst, idle);
      if (i < 7) copi = data[6-i];
      waitClk(Half);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [7:0] host, output logic [7:0] miso);
    csAssert(inst);
    sendBits(inst, host, 8, miso);
    csRelease(inst);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h3C};
    vecs[1] = '{0, 8'h00, 8'hFF};
    vecs[2] = '{0, 8'hFF, 8'h00};
    vecs[3] = '{0, 8'h96, 8'h5A};
    vecs[4] = '{1, 8'h81, 8'h81};
    vecs[5] = '{1, 8'h3C, 8'hC5};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    sck0 = 1'b0; sck1 = 1'b1; csn0 = 1'b1; csn1 = 1'b1; copi = 1'b0;
    waitClk(3);
    checkOutput("reset_rvalid", rvalid0, 32'h0);
    checkOutput("reset_rdata", rdata0, 32'h0);
    checkOutput("reset_cipo", cipo0, 32'h0);
    checkOutput("reset_irq", irq0, 32'h0);
    rst_n = 1'b1;
    waitClk(4);
    regRead(0, 32'h4, rd);
    checkOutput("reset_status", rd, 32'h1);

    // Single-byte transfers in both clock polarities.
    for (int v = 0; v < 6; v++) begin
      regWrite(vecs[v].inst, 32'h8, {24'h0, vecs[v].txdata});
      applyStimulus(vecs[v].inst, vecs[v].host, m);
      checkOutput("host_rx", m, vecs[v].txdata);
      checkOutput("irq_set", getIrq(vecs[v].inst), 32'h1);
      regRead(vecs[v].inst, 32'h0, rd);
      checkOutput("rxdata", rd, {24'h0, vecs[v].host});
      regRead(vecs[v].inst, 32'h4, rd);
      checkOutput("status_empty", rd, 32'h1);
    end

    regRead(0, 32'h0, rd);
    checkOutput("rxdata_empty", rd, 32'h0);
    regRead(0, 32'h8, rd);
    checkOutput("txdata_unreadable", rd, 32'h0);
    regRead(0, 32'hC, rd);
    checkOutput("unmapped", rd, 32'h0);

    // RxDepth+1 bytes in one CS window; TXDATA rewritten mid-stream.
    regWrite(0, 32'h8, 32'h5A);
    csAssert(0);
    for (int i = 0; i < 17; i++) begin
      sendBits(0, 8'(8'h10 + i), 8, m);
      if (i == 0) begin
        checkOutput("tx_byte0", m, 32'h5A);
        regWrite(0, 32'h8, 32'h3C);
      end
      if (i == 1) checkOutput("tx_byte1", m, 32'h5A);
      if (i == 2) checkOutput("tx_byte2", m, 32'h3C);
    end
    csRelease(0);
    regRead(0, 32'h4, rd);
    checkOutput("status_ovf_full", rd, 32'h6);
    for (int i = 0; i < 16; i++) begin
      regRead(0, 32'h0, rd);
      checkOutput("fifo_order", rd, 32'h10 + i);
    end
    regRead(0, 32'h4, rd);
    checkOutput("status_ovf_sticky", rd, 32'h5);
    regWrite(0, 32'h4, 32'h0);
    regRead(0, 32'h4, rd);
    checkOutput("ovf_no_clear", rd, 32'h5);
    regWrite(0, 32'h4, 32'h4);
    regRead(0, 32'h4, rd);
    checkOutput("ovf_cleared", rd, 32'h1);

    // CS raised after 5 bits.
    csAssert(0);
    regRead(0, 32'h4, rd);
    checkOutput("status_cs_active", rd, 32'h9);
    sendBits(0, 8'hFF, 5, m);
    csRelease(0);
    regRead(0, 32'h4, rd);
    checkOutput("partial_no_push", rd, 32'h1);
    checkOutput("partial_irq", irq0, 32'h0);
    applyStimulus(0, 8'hC3, m);
    regRead(0, 32'h0, rd);
    checkOutput("after_partial", rd, 32'hC3);

    // Pop coincident with push at depth 1.
    applyStimulus(0, 8'h11, m);
    csAssert(0);
    sendBits(0, 8'h22, 7, m);
    sck0 = 1'b1;
    waitClk(2);
    regRead(0, 32'h0, rd);
    checkOutput("coincident_pop", rd, 32'h11);
    waitClk(Half - 3);
    sck0 = 1'b0;
    waitClk(Half);
    csRelease(0);
    regRead(0, 32'h4, rd);
    checkOutput("depth_one", rd, 32'h0);
    regRead(0, 32'h0, rd);
    checkOutput("coincident_next", rd, 32'h22);
    regRead(0, 32'h4, rd);
    checkOutput("coincident_empty", rd, 32'h1);

    // Reset in the middle of a byte.
    regWrite(0, 32'h8, 32'hFF);
    applyStimulus(0, 8'h77, m);
    applyStimulus(0, 8'h78, m);
    regRead(0, 32'h0, rd);
    checkOutput("pre_reset_read", rd, 32'h77);
    csAssert(0);
    sendBits(0, 8'hAA, 3, m);
    checkOutput("pre_reset_cipo", cipo0, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_cipo", cipo0, 32'h0);
    checkOutput("mid_reset_irq", irq0, 32'h0);
    checkOutput("mid_reset_rdata", rdata0, 32'h0);
    checkOutput("mid_reset_rvalid", rvalid0, 32'h0);
    waitClk(2);
    rst_n = 1'b1;
    waitClk(2);
    sendBits(0, 8'hAA, 5, m);
    checkOutput("post_reset_cipo", m, 32'h0);
    regRead(0, 32'h4, rd);
    checkOutput("post_reset_status", rd, 32'h1);
    csRelease(0);
    applyStimulus(0, 8'h77, m);
    checkOutput("txdata_reset", m, 32'h0);
    regRead(0, 32'h0, rd);
    checkOutput("post_reset_rx", rd, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
